// File: rtl/node_network_interface_if.sv
// Bundles the PE-side and router-side flit, handshake, credit and error signals of the NI.
// The slave modport is the NI's view; the master modport is the environment driving it.
interface node_network_interface_if #(
  parameter int unsigned FLIT_W = 20
);
  logic [FLIT_W-1:0] pe_in_data;
  logic              pe_in_valid;
  logic              pe_in_ready;
  logic [FLIT_W-1:0] rt_out_data;
  logic              rt_out_valid;
  logic              rt_credit_in;
  logic [FLIT_W-1:0] rt_in_data;
  logic              rt_in_valid;
  logic              rt_credit_out;
  logic [FLIT_W-1:0] pe_out_data;
  logic              pe_out_valid;
  logic              pe_out_ready;
  logic              err_credit;
  logic              err_eject;

  modport slave (
    input  pe_in_data, pe_in_valid, rt_credit_in, rt_in_data, rt_in_valid, pe_out_ready,
    output pe_in_ready, rt_out_data, rt_out_valid, rt_credit_out, pe_out_data, pe_out_valid,
           err_credit, err_eject
  );

  modport master (
    output pe_in_data, pe_in_valid, rt_credit_in, rt_in_data, rt_in_valid, pe_out_ready,
    input  pe_in_ready, rt_out_data, rt_out_valid, rt_credit_out, pe_out_data, pe_out_valid,
           err_credit, err_eject
  );
endinterface

// File: rtl/node_network_interface.sv
// Network interface between a router local port and its PE: injection FIFO with credit-based
// sending toward the router, FWFT ejection FIFO returning one credit per consumed flit.
module node_network_interface #(
  parameter int unsigned FLIT_W     = 20,
  parameter int unsigned INJ_DEPTH  = 8,
  parameter int unsigned EJ_DEPTH   = 4,
  parameter int unsigned RT_CREDITS = 4
) (
  input logic                    clk,
  input logic                    RST,
  node_network_interface_if.slave bus
);

  localparam int unsigned IAW = $clog2(INJ_DEPTH);
  localparam int unsigned EAW = $clog2(EJ_DEPTH);
  localparam int unsigned CW  = $clog2(RT_CREDITS + 1);

  localparam logic [CW-1:0]  CreditMax = CW'(RT_CREDITS);
  localparam logic [CW-1:0]  CreditOne = CW'(1);
  localparam logic [IAW:0]   InjOne    = (IAW + 1)'(1);
  localparam logic [EAW:0]   EjOne     = (EAW + 1)'(1);

  // Injection FIFO
  logic [FLIT_W-1:0] inj_mem [INJ_DEPTH];
  logic [IAW:0]      inj_wptr_q, inj_rptr_q;
  logic              inj_full, inj_empty, inj_push, send;

  // Ejection FIFO
  logic [FLIT_W-1:0] ej_mem [EJ_DEPTH];
  logic [EAW:0]      ej_wptr_q, ej_rptr_q;
  logic              ej_full, ej_empty, ej_push, ej_pop;

  logic [CW-1:0]     credit_q, credit_d;
  logic              err_credit_q, err_credit_d;
  logic              err_eject_q, err_eject_d;
  logic [FLIT_W-1:0] rt_out_data_q;
  logic              rt_out_valid_q;
  logic              rt_credit_out_q;

  // Full when pointers match in the low bits but differ in the wrap bit.
  assign inj_empty = (inj_wptr_q == inj_rptr_q);
  assign inj_full  = (inj_wptr_q[IAW] != inj_rptr_q[IAW]) &&
                     (inj_wptr_q[IAW-1:0] == inj_rptr_q[IAW-1:0]);
  assign ej_empty  = (ej_wptr_q == ej_rptr_q);
  assign ej_full   = (ej_wptr_q[EAW] != ej_rptr_q[EAW]) &&
                     (ej_wptr_q[EAW-1:0] == ej_rptr_q[EAW-1:0]);

  // Full status is taken before any same-cycle pop, so a pop never makes room this cycle.
  assign inj_push = bus.pe_in_valid & ~inj_full;
  assign send     = ~inj_empty & (credit_q != '0);
  assign ej_push  = bus.rt_in_valid & ~ej_full;
  assign ej_pop   = ~ej_empty & bus.pe_out_ready;

  always_comb begin
    credit_d     = credit_q;
    err_credit_d = err_credit_q;
    unique case ({send, bus.rt_credit_in})
      2'b10: credit_d = credit_q - CreditOne;
      2'b01: begin
        if (credit_q == CreditMax) err_credit_d = 1'b1;
        else                       credit_d     = credit_q + CreditOne;
      end
      default: ;
    endcase
  end

  assign err_eject_d = err_eject_q | (bus.rt_in_valid & ej_full);

  always_ff @(posedge clk) begin
    if (RST) begin
      inj_wptr_q      <= '0;
      inj_rptr_q      <= '0;
      ej_wptr_q       <= '0;
      ej_rptr_q       <= '0;
      credit_q        <= CreditMax;
      err_credit_q    <= 1'b0;
      err_eject_q     <= 1'b0;
      rt_out_data_q   <= '0;
      rt_out_valid_q  <= 1'b0;
      rt_credit_out_q <= 1'b0;
    end else begin
      if (inj_push) inj_wptr_q <= inj_wptr_q + InjOne;
      if (send) begin
        inj_rptr_q    <= inj_rptr_q + InjOne;
        rt_out_data_q <= inj_mem[inj_rptr_q[IAW-1:0]];
      end
      rt_out_valid_q  <= send;
      if (ej_push) ej_wptr_q <= ej_wptr_q + EjOne;
      if (ej_pop)  ej_rptr_q <= ej_rptr_q + EjOne;
      rt_credit_out_q <= ej_pop;
      credit_q        <= credit_d;
      err_credit_q    <= err_credit_d;
      err_eject_q     <= err_eject_d;
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wptr_q[IAW-1:0]] <= bus.pe_in_data;
    if (ej_push)  ej_mem[ej_wptr_q[EAW-1:0]]   <= bus.rt_in_data;
  end

  assign bus.pe_in_ready   = ~inj_full;
  assign bus.rt_out_data   = rt_out_data_q;
  assign bus.rt_out_valid  = rt_out_valid_q;
  assign bus.rt_credit_out = rt_credit_out_q;
  assign bus.pe_out_data   = ej_mem[ej_rptr_q[EAW-1:0]];
  assign bus.pe_out_valid  = ~ej_empty;
  assign bus.err_credit    = err_credit_q;
  assign bus.err_eject     = err_eject_q;

endmodule

// File: tb/tb_node_network_interface.sv
// Self-checking bench for node_network_interface: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_node_network_interface;

  localparam int unsigned FLIT_W     = 20;
  localparam int unsigned INJ_DEPTH  = 8;
  localparam int unsigned EJ_DEPTH   = 4;
  localparam int unsigned RT_CREDITS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  node_network_interface_if #(.FLIT_W(FLIT_W)) bus ();

  node_network_interface #(
    .FLIT_W    (FLIT_W),
    .INJ_DEPTH (INJ_DEPTH),
    .EJ_DEPTH  (EJ_DEPTH),
    .RT_CREDITS(RT_CREDITS)
  ) dut (
    .clk(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flits held in queues, credits as a plain integer.
  logic [FLIT_W-1:0] inj_q[$];
  logic [FLIT_W-1:0] ej_q[$];
  int                m_credit;
  bit                m_rtv, m_cro, m_errc, m_erre;
  logic [FLIT_W-1:0] m_rtd;

  task automatic model_check();
    check("model pe_in_ready", bus.pe_in_ready, inj_q.size() < INJ_DEPTH);
    check("model pe_out_valid", bus.pe_out_valid, ej_q.size() != 0);
    if (ej_q.size() != 0) check("model pe_out_data", bus.pe_out_data, ej_q[0]);
    check("model rt_out_valid", bus.rt_out_valid, m_rtv);
    check("model rt_out_data", bus.rt_out_data, m_rtd);
    check("model rt_credit_out", bus.rt_credit_out, m_cro);
    check("model err_credit", bus.err_credit, m_errc);
    check("model err_eject", bus.err_eject, m_erre);
  endtask

  task automatic model_update();
    bit send, push, pop, ej_was_full;
    if (rst) begin
      inj_q.delete();
      ej_q.delete();
      m_credit = RT_CREDITS;
      m_rtv = 0; m_rtd = '0; m_cro = 0; m_errc = 0; m_erre = 0;
    end else begin
      send        = (inj_q.size() > 0) && (m_credit > 0);
      push        = bus.pe_in_valid && (inj_q.size() < INJ_DEPTH);
      pop         = (ej_q.size() > 0) && bus.pe_out_ready;
      ej_was_full = (ej_q.size() == EJ_DEPTH);
      m_rtv = send;
      if (send) m_rtd = inj_q.pop_front();
      if (push) inj_q.push_back(bus.pe_in_data);
      if (bus.rt_credit_in && !send && m_credit == RT_CREDITS) m_errc = 1;
      else m_credit = m_credit - int'(send) + int'(bus.rt_credit_in);
      m_cro = pop;
      if (pop) void'(ej_q.pop_front());
      if (bus.rt_in_valid) begin
        if (ej_was_full) m_erre = 1;
        else ej_q.push_back(bus.rt_in_data);
      end
    end
  endtask

  // Called at the falling edge; leaves the bench 1 time unit after the next rising edge.
  task automatic advance();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #4;
    advance();
  endtask

  task automatic idle_inputs();
    bus.pe_in_valid  = 0;
    bus.pe_in_data   = '0;
    bus.rt_credit_in = 0;
    bus.rt_in_valid  = 0;
    bus.rt_in_data   = '0;
    bus.pe_out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  typedef struct {
    bit                vin;
    logic [FLIT_W-1:0] din;
    bit                cin;
    bit                exp_rdy;
    bit                exp_v;
    logic [FLIT_W-1:0] exp_d;
  } vec_t;

  vec_t tv[14];
  int   accepted, strobes;
  bit   acc;
  logic [FLIT_W-1:0] data;

  initial begin
    // Tests 1-2: six pushes with four credits, then two returned credits release the rest.
    tv[0]  = '{1, 20'h00001, 0, 1, 0, 20'h00000};
    tv[1]  = '{1, 20'h00002, 0, 1, 0, 20'h00000};
    tv[2]  = '{1, 20'h00003, 0, 1, 1, 20'h00001};
    tv[3]  = '{1, 20'h00004, 0, 1, 1, 20'h00002};
    tv[4]  = '{1, 20'h00005, 0, 1, 1, 20'h00003};
    tv[5]  = '{1, 20'h00006, 0, 1, 1, 20'h00004};
    tv[6]  = '{0, 20'h00000, 0, 1, 0, 20'h00004};
    tv[7]  = '{0, 20'h00000, 0, 1, 0, 20'h00004};
    tv[8]  = '{0, 20'h00000, 1, 1, 0, 20'h00004};
    tv[9]  = '{0, 20'h00000, 0, 1, 0, 20'h00004};
    tv[10] = '{0, 20'h00000, 1, 1, 1, 20'h00005};
    tv[11] = '{0, 20'h00000, 0, 1, 0, 20'h00005};
    tv[12] = '{0, 20'h00000, 0, 1, 1, 20'h00006};
    tv[13] = '{0, 20'h00000, 0, 1, 0, 20'h00006};

    idle_inputs();
    rst = 1;
    model_update();
    @(posedge clk);
    #1;
    do_reset();

    check("rst pe_in_ready", bus.pe_in_ready, 1);
    check("rst pe_out_valid", bus.pe_out_valid, 0);
    check("rst rt_out_valid", bus.rt_out_valid, 0);
    check("rst rt_out_data", bus.rt_out_data, 0);
    check("rst rt_credit_out", bus.rt_credit_out, 0);
    check("rst err_credit", bus.err_credit, 0);
    check("rst err_eject", bus.err_eject, 0);

    for (int i = 0; i < 14; i++) begin
      bus.pe_in_valid  = tv[i].vin;
      bus.pe_in_data   = tv[i].din;
      bus.rt_credit_in = tv[i].cin;
      #4;
      check($sformatf("vec%0d pe_in_ready", i), bus.pe_in_ready, tv[i].exp_rdy);
      check($sformatf("vec%0d rt_out_valid", i), bus.rt_out_valid, tv[i].exp_v);
      check($sformatf("vec%0d rt_out_data", i), bus.rt_out_data, tv[i].exp_d);
      advance();
    end

    // Test 3: drain all credits, then offer nine flits; only eight fit.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.pe_in_valid = 1;
      bus.pe_in_data  = FLIT_W'(32'h10 + i);
      step();
    end
    bus.pe_in_valid = 0;
    for (int i = 0; i < 6; i++) step();
    accepted = 0;
    data = 20'h00100;
    for (int i = 0; i < 12; i++) begin
      bus.pe_in_valid = 1;
      bus.pe_in_data  = data;
      acc = bus.pe_in_ready;
      step();
      if (acc) begin
        accepted++;
        data = data + 1'b1;
      end
    end
    check("t3 accepted", accepted, 8);
    check("t3 ready_low", bus.pe_in_ready, 0);
    bus.pe_in_valid = 0;

    // Test 4: second credit arrives in the same cycle as a send; only two sends follow.
    strobes = 0;
    bus.rt_credit_in = 1;
    step();
    strobes += int'(bus.rt_out_valid);
    step();
    strobes += int'(bus.rt_out_valid);
    bus.rt_credit_in = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      strobes += int'(bus.rt_out_valid);
    end
    check("t4 strobes", strobes, 2);
    check("t4 err_credit", bus.err_credit, 0);

    // Test 5: spurious credit at full count is flagged and the counter stays at four.
    do_reset();
    bus.rt_credit_in = 1;
    step();
    bus.rt_credit_in = 0;
    check("t5 err_credit set", bus.err_credit, 1);
    strobes = 0;
    for (int i = 0; i < 11; i++) begin
      bus.pe_in_valid = (i < 5);
      bus.pe_in_data  = FLIT_W'(32'h200 + i);
      step();
      strobes += int'(bus.rt_out_valid);
    end
    bus.pe_in_valid = 0;
    check("t5 strobes", strobes, 4);
    check("t5 err_credit sticky", bus.err_credit, 1);
    do_reset();
    check("t5 err_credit cleared", bus.err_credit, 0);

    // Test 6: overflow the ejection FIFO, then drain it and watch the credit pulses.
    bus.pe_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.rt_in_valid = 1;
      bus.rt_in_data  = FLIT_W'(32'hA0 + i);
      step();
    end
    bus.rt_in_valid = 0;
    check("t6 err_eject", bus.err_eject, 1);
    check("t6 head_valid", bus.pe_out_valid, 1);
    check("t6 head_data", bus.pe_out_data, 32'hA0);
    bus.pe_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #4;
      check($sformatf("t6 pop%0d valid", i), bus.pe_out_valid, (i < 4));
      if (i < 4) check($sformatf("t6 pop%0d data", i), bus.pe_out_data, 32'hA0 + i);
      check($sformatf("t6 cyc%0d credit_out", i), bus.rt_credit_out, (i >= 1 && i <= 4));
      advance();
    end
    check("t6 err_eject sticky", bus.err_eject, 1);

    // Randomized traffic against the model, with occasional mid-run resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 399) == 0);
      bus.pe_in_valid  = ($urandom_range(0, 9) < 6);
      bus.pe_in_data   = FLIT_W'($urandom);
      bus.rt_credit_in = ($urandom_range(0, 9) < 2);
      bus.rt_in_valid  = ($urandom_range(0, 9) < 4);
      bus.rt_in_data   = FLIT_W'($urandom);
      bus.pe_out_ready = ($urandom_range(0, 9) < 5);
      step();
    end
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
